wii_classic_poller: RTL and testbench

Transaction sequencer between the byte-level I2C master and the top level. It initialises a Wii Classic Controller at I2C address 0x52 in unencrypted mode, then polls it periodically for its 6-byte report. It decodes the report into active-high button and stick fields for the display and debug logic. It drives only byte-level commands; SDA/SCL timing belongs to the I2C master.

---
 rtl/wii_classic_poller.sv | 270 +++++++++++++++++++++++++++
 tb/tb_wii_classic_poller.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wii_classic_poller.sv
// rtl/wii_classic_poller.sv - Wii Classic Controller init/poll sequencer and report decoder
// Optional WII_CAL_EN: recentre sticks using the first report after each init as the centre.
module wii_classic_poller #(
  parameter int POLL_CYCLES   = 1000000,
  parameter int SETTLE_CYCLES = 20000,
  parameter int RETRY_CYCLES  = 5000000,
  parameter int SIMULATE      = 0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [1:0] cmd_op,
  output logic [7:0] cmd_data,
  output logic       cmd_last,
  input  logic       rsp_valid,
  input  logic       rsp_nack,
  input  logic [7:0] rsp_data,
  output logic       connected,
  output logic [3:0] udlr_dpad,
  output logic [3:0] abxy_btns,
  output logic [4:0] l_trig_btn,
  output logic [4:0] r_trig_btn,
  output logic [1:0] lr_z_btns,
  output logic [2:0] st_sel_hm_btns,
  output logic [5:0] l_stick_x,
  output logic [5:0] l_stick_y,
  output logic [4:0] r_stick_x,
  output logic [4:0] r_stick_y
);
  localparam int POLL_N   = (SIMULATE != 0) ? 1000 : POLL_CYCLES;
  localparam int SETTLE_N = (SIMULATE != 0) ? 100  : SETTLE_CYCLES;
  localparam int RETRY_N  = (SIMULATE != 0) ? 500  : RETRY_CYCLES;

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_STOP  = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_INIT1, S_INIT2, S_PTR, S_SETTLE, S_READ,
    S_DECODE, S_WAITPOLL, S_ERRSTOP, S_BACKOFF
  } state_t;

  state_t      state;
  logic        pending;
  logic [2:0]  step;
  logic [31:0] tmr;
  logic [31:0] poll_cnt;

  // Only the report bits that feed an output are kept.
  logic [5:0] cap_lx, cap_ly;
  logic [4:0] cap_rx, cap_ry;
  logic [3:0] cap_lt, cap_rt;
  logic [7:1] cap_b4;
  logic [7:0] cap_b5;

  logic [1:0] nxt_op;
  logic [7:0] nxt_data;
  logic       nxt_last;
  logic [2:0] final_step;

  always_comb begin
    nxt_op     = OP_STOP;
    nxt_data   = 8'h00;
    nxt_last   = 1'b0;
    final_step = 3'd0;
    case (state)
      S_INIT1, S_INIT2: begin
        final_step = 3'd3;
        case (step)
          3'd0: begin nxt_op = OP_START; nxt_data = 8'hA4; end
          3'd1: begin nxt_op = OP_WRITE; nxt_data = (state == S_INIT1) ? 8'hF0 : 8'hFB; end
          3'd2: begin nxt_op = OP_WRITE; nxt_data = (state == S_INIT1) ? 8'h55 : 8'h00; end
          default: ;
        endcase
      end
      S_PTR: begin
        final_step = 3'd2;
        case (step)
          3'd0: begin nxt_op = OP_START; nxt_data = 8'hA4; end
          3'd1: begin nxt_op = OP_WRITE; nxt_data = 8'h00; end
          default: ;
        endcase
      end
      S_READ: begin
        final_step = 3'd7;
        if (step == 3'd0) begin
          nxt_op   = OP_START;
          nxt_data = 8'hA5;
        end else if (step != 3'd7) begin
          nxt_op   = OP_READ;
          nxt_last = (step == 3'd6);
        end
      end
      default: ;
    endcase
  end

  logic [5:0] out_lx, out_ly;
  logic [4:0] out_rx, out_ry;
  logic       upd;

`ifdef WII_CAL_EN
  logic       cal_valid;
  logic [5:0] ctr_lx, ctr_ly;
  logic [4:0] ctr_rx, ctr_ry;

  function automatic logic [5:0] cal6(input logic [5:0] raw, input logic [5:0] ctr);
    int v;
    v = int'(raw) - int'(ctr) + 32;
    if (v < 0) v = 0;
    else if (v > 63) v = 63;
    return v[5:0];
  endfunction

  function automatic logic [4:0] cal5(input logic [4:0] raw, input logic [4:0] ctr);
    int v;
    v = int'(raw) - int'(ctr) + 16;
    if (v < 0) v = 0;
    else if (v > 31) v = 31;
    return v[4:0];
  endfunction

  assign out_lx = cal6(cap_lx, ctr_lx);
  assign out_ly = cal6(cap_ly, ctr_ly);
  assign out_rx = cal5(cap_rx, ctr_rx);
  assign out_ry = cal5(cap_ry, ctr_ry);
  assign upd    = cal_valid;
`else
  assign out_lx = cap_lx;
  assign out_ly = cap_ly;
  assign out_rx = cap_rx;
  assign out_ry = cap_ry;
  assign upd    = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      pending   <= 1'b0;
      step      <= 3'd0;
      tmr       <= 32'd0;
      poll_cnt  <= 32'd0;
      cmd_valid <= 1'b0;
      cmd_op    <= 2'd0;
      cmd_data  <= 8'h00;
      cmd_last  <= 1'b0;
      {cap_lx, cap_ly, cap_rx, cap_ry, cap_lt, cap_rt, cap_b4, cap_b5} <= '0;
      {connected, udlr_dpad, abxy_btns, l_trig_btn, r_trig_btn, lr_z_btns,
       st_sel_hm_btns, l_stick_x, l_stick_y, r_stick_x, r_stick_y} <= '0;
`ifdef WII_CAL_EN
      cal_valid <= 1'b0;
      {ctr_lx, ctr_ly, ctr_rx, ctr_ry} <= '0;
`endif
    end else begin
      if (poll_cnt != 32'hFFFF_FFFF) poll_cnt <= poll_cnt + 32'd1;
      if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
        pending   <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          state <= S_INIT1;
          step  <= 3'd0;
`ifdef WII_CAL_EN
          cal_valid <= 1'b0;
`endif
        end
        S_INIT1, S_INIT2, S_PTR, S_READ, S_ERRSTOP: begin
          if (!cmd_valid && !pending) begin
            cmd_valid <= 1'b1;
            cmd_op    <= nxt_op;
            cmd_data  <= nxt_data;
            cmd_last  <= nxt_last;
          end else if (pending && rsp_valid) begin
            pending <= 1'b0;
            if (rsp_nack && (cmd_op == OP_START || cmd_op == OP_WRITE)) begin
              state <= S_ERRSTOP;
              step  <= 3'd0;
              {connected, udlr_dpad, abxy_btns, l_trig_btn, r_trig_btn, lr_z_btns,
               st_sel_hm_btns, l_stick_x, l_stick_y, r_stick_x, r_stick_y} <= '0;
            end else begin
              if (cmd_op == OP_READ) begin
                case (step)
                  3'd1: begin cap_lx <= rsp_data[5:0]; cap_rx[4:3] <= rsp_data[7:6]; end
                  3'd2: begin cap_ly <= rsp_data[5:0]; cap_rx[2:1] <= rsp_data[7:6]; end
                  3'd3: begin
                    cap_rx[0]   <= rsp_data[7];
                    cap_lt[3:2] <= rsp_data[6:5];
                    cap_ry      <= rsp_data[4:0];
                  end
                  3'd4: begin cap_lt[1:0] <= rsp_data[7:6]; cap_rt <= rsp_data[4:1]; end
                  3'd5: cap_b4 <= rsp_data[7:1];
                  3'd6: cap_b5 <= rsp_data;
                  default: ;
                endcase
              end
              if (step == final_step) begin
                step <= 3'd0;
                case (state)
                  S_INIT1: state <= S_INIT2;
                  S_INIT2: begin state <= S_PTR; poll_cnt <= 32'd0; end
                  S_PTR: begin state <= S_SETTLE; tmr <= 32'(SETTLE_N - 1); end
                  S_READ: state <= S_DECODE;
                  default: begin state <= S_BACKOFF; tmr <= 32'(RETRY_N - 1); end
                endcase
              end else begin
                step <= step + 3'd1;
              end
            end
          end
        end
        S_SETTLE: begin
          if (tmr == 32'd0) begin
            state <= S_READ;
            step  <= 3'd0;
          end else begin
            tmr <= tmr - 32'd1;
          end
        end
        S_DECODE: begin
          state <= S_WAITPOLL;
`ifdef WII_CAL_EN
          if (!cal_valid) begin
            cal_valid <= 1'b1;
            ctr_lx <= cap_lx;
            ctr_ly <= cap_ly;
            ctr_rx <= cap_rx;
            ctr_ry <= cap_ry;
          end
`endif
          if (upd) begin
            connected      <= 1'b1;
            udlr_dpad      <= {~cap_b5[0], ~cap_b4[6], ~cap_b5[1], ~cap_b4[7]};
            abxy_btns      <= {~cap_b5[4], ~cap_b5[6], ~cap_b5[3], ~cap_b5[5]};
            l_trig_btn     <= {~cap_b4[5], cap_lt};
            r_trig_btn     <= {~cap_b4[1], cap_rt};
            lr_z_btns      <= {~cap_b5[7], ~cap_b5[2]};
            st_sel_hm_btns <= {~cap_b4[2], ~cap_b4[4], ~cap_b4[3]};
            l_stick_x      <= out_lx;
            l_stick_y      <= out_ly;
            r_stick_x      <= out_rx;
            r_stick_y      <= out_ry;
          end
        end
        S_WAITPOLL: begin
          // poll_cnt counts from the previous PTR entry, so a late arrival exits at once.
          if (poll_cnt >= 32'(POLL_N - 1)) begin
            state    <= S_PTR;
            step     <= 3'd0;
            poll_cnt <= 32'd0;
          end
        end
        S_BACKOFF: begin
          if (tmr == 32'd0) begin
            state <= S_INIT1;
            step  <= 3'd0;
`ifdef WII_CAL_EN
            cal_valid <= 1'b0;
`endif
          end else begin
            tmr <= tmr - 32'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wii_classic_poller.sv
// tb/tb_wii_classic_poller.sv - directed scoreboard bench for wii_classic_poller (SIMULATE=1)
module tb_wii_classic_poller;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_ready = 1'b0;
  logic       rsp_valid = 1'b0;
  logic       rsp_nack = 1'b0;
  logic [7:0] rsp_data = 8'h00;
  logic       cmd_valid, cmd_last, connected;
  logic [1:0] cmd_op, lr_z_btns;
  logic [7:0] cmd_data;
  logic [3:0] udlr_dpad, abxy_btns;
  logic [4:0] l_trig_btn, r_trig_btn, r_stick_x, r_stick_y;
  logic [2:0] st_sel_hm_btns;
  logic [5:0] l_stick_x, l_stick_y;

  wii_classic_poller #(.SIMULATE(1)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_last(cmd_last),
    .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_data(rsp_data),
    .connected(connected), .udlr_dpad(udlr_dpad), .abxy_btns(abxy_btns),
    .l_trig_btn(l_trig_btn), .r_trig_btn(r_trig_btn), .lr_z_btns(lr_z_btns),
    .st_sel_hm_btns(st_sel_hm_btns), .l_stick_x(l_stick_x), .l_stick_y(l_stick_y),
    .r_stick_x(r_stick_x), .r_stick_y(r_stick_y)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       conn;
    logic [3:0] dpad;
    logic [3:0] abxy;
    logic [4:0] lt;
    logic [4:0] rt;
    logic [1:0] z;
    logic [2:0] ssh;
    logic [5:0] lx;
    logic [5:0] ly;
    logic [4:0] rx;
    logic [4:0] ry;
  } outs_t;

  int    n_tests = 0;
  int    n_fail = 0;
  outs_t exp_q[$];
  outs_t m_cur;
  logic  m_cal;
  int    last_rise, last_rsp, ptr_rise, ptr_stop_rsp;
`ifdef WII_CAL_EN
  logic [5:0] c_lx, c_ly;
  logic [4:0] c_rx, c_ry;
  localparam logic [47:0] R1 = 48'hE4_60_90_4F_FF_EF;
`else
  localparam logic [47:0] R1 = 48'hE0_60_90_4F_FF_EF;
`endif
  localparam logic [47:0] R2 = 48'h30_BF_0A_A3_01_10;
  localparam logic [47:0] R3 = 48'hFF_FF_FF_FF_FF_FF;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs_v, input logic [63:0] exp_v);
    n_tests++;
    assert (obs_v === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs_v, exp_v);
    end
  endtask

  function automatic outs_t obs();
    return {connected, udlr_dpad, abxy_btns, l_trig_btn, r_trig_btn, lr_z_btns,
            st_sel_hm_btns, l_stick_x, l_stick_y, r_stick_x, r_stick_y};
  endfunction

  // Reference decode written from the controller's report layout (buttons active low).
  function automatic outs_t decode_raw(input logic [47:0] r);
    logic [7:0] b0, b1, b2, b3, b4, b5;
    logic [4:0] lt_an, rt_an;
    logic up, down, left, right, ba, bb, bx, by, zl, zr, lt, rt, st, sel, hm;
    outs_t e;
    {b0, b1, b2, b3, b4, b5} = r;
    right = !b4[7]; down = !b4[6]; lt = !b4[5]; sel = !b4[4]; hm = !b4[3]; st = !b4[2]; rt = !b4[1];
    zl = !b5[7]; bb = !b5[6]; by = !b5[5]; ba = !b5[4]; bx = !b5[3]; zr = !b5[2]; left = !b5[1]; up = !b5[0];
    lt_an = {b2[6:5], b3[7:5]};
    rt_an = b3[4:0];
    e.conn = 1'b1;
    e.dpad = {up, down, left, right};
    e.abxy = {ba, bb, bx, by};
    e.lt   = {lt, lt_an[4:1]};
    e.rt   = {rt, rt_an[4:1]};
    e.z    = {zl, zr};
    e.ssh  = {st, sel, hm};
    e.lx   = b0[5:0];
    e.ly   = b1[5:0];
    e.rx   = {b0[7:6], b1[7:6], b2[7]};
    e.ry   = b2[4:0];
    return e;
  endfunction

  function automatic int clampi(input int v, input int mx);
    if (v < 0) return 0;
    if (v > mx) return mx;
    return v;
  endfunction

  task automatic push_expect(input logic [47:0] r);
    outs_t e;
    e = decode_raw(r);
`ifdef WII_CAL_EN
    if (!m_cal) begin
      m_cal = 1'b1;
      c_lx = e.lx; c_ly = e.ly; c_rx = e.rx; c_ry = e.ry;
      e = m_cur;
    end else begin
      e.lx = 6'(clampi(int'(e.lx) - int'(c_lx) + 32, 63));
      e.ly = 6'(clampi(int'(e.ly) - int'(c_ly) + 32, 63));
      e.rx = 5'(clampi(int'(e.rx) - int'(c_rx) + 16, 31));
      e.ry = 5'(clampi(int'(e.ry) - int'(c_ry) + 16, 31));
    end
`endif
    m_cur = e;
    exp_q.push_back(e);
  endtask

  task automatic model_clear();
    m_cur = '0;
    m_cal = 1'b0;
  endtask

  // Slave side of one command: random accept delay, hold/outstanding checks, one response.
  task automatic serve(input logic nack, input logic [7:0] rdata,
                       output logic [1:0] op, output logic [7:0] data, output logic last);
    int   n;
    int   d;
    logic ok;
    n = 0;
    while (cmd_valid !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    last_rise = cyc;
    chk("cmd_wait", 64'(cmd_valid), 64'd1);
    op = cmd_op; data = cmd_data; last = cmd_last; ok = 1'b1;
    d = $urandom_range(0, 5);
    repeat (d) begin
      tick();
      if (cmd_valid !== 1'b1 || cmd_op !== op || cmd_data !== data || cmd_last !== last) ok = 1'b0;
    end
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    d = $urandom_range(1, 4);
    repeat (d) begin
      if (cmd_valid !== 1'b0) ok = 1'b0;
      tick();
    end
    rsp_valid = 1'b1; rsp_nack = nack; rsp_data = rdata;
    tick();
    last_rsp = cyc;
    rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = 8'h00;
    chk("cmd_hold", 64'(ok), 64'd1);
  endtask

  task automatic xcmd(input string tag, input logic nack, input logic [7:0] rdata,
                      input logic [1:0] eop, input logic [7:0] edata, input logic elast);
    logic [1:0] op;
    logic [7:0] data;
    logic       last;
    serve(nack, rdata, op, data, last);
    chk({tag, "_op"}, 64'(op), 64'(eop));
    if (eop < 2'd2) chk({tag, "_data"}, 64'(data), 64'(edata));
    chk({tag, "_last"}, 64'(last), 64'(elast));
  endtask

  task automatic do_init1();
    m_cal = 1'b0;
    xcmd("i1_start", 1'b0, 8'h00, 2'd0, 8'hA4, 1'b0);
    xcmd("i1_f0",    1'b0, 8'h00, 2'd1, 8'hF0, 1'b0);
    xcmd("i1_55",    1'b0, 8'h00, 2'd1, 8'h55, 1'b0);
    xcmd("i1_stop",  1'b0, 8'h00, 2'd3, 8'h00, 1'b0);
  endtask

  task automatic do_init2();
    xcmd("i2_start", 1'b0, 8'h00, 2'd0, 8'hA4, 1'b0);
    xcmd("i2_fb",    1'b0, 8'h00, 2'd1, 8'hFB, 1'b0);
    xcmd("i2_00",    1'b0, 8'h00, 2'd1, 8'h00, 1'b0);
    xcmd("i2_stop",  1'b0, 8'h00, 2'd3, 8'h00, 1'b0);
  endtask

  task automatic do_ptr();
    xcmd("ptr_start", 1'b0, 8'h00, 2'd0, 8'hA4, 1'b0);
    ptr_rise = last_rise;
    xcmd("ptr_00",    1'b0, 8'h00, 2'd1, 8'h00, 1'b0);
    xcmd("ptr_stop",  1'b0, 8'h00, 2'd3, 8'h00, 1'b0);
    ptr_stop_rsp = last_rsp;
  endtask

  task automatic do_read(input string tag, input logic [47:0] r);
    outs_t e;
    push_expect(r);
    xcmd({tag, "_start"}, 1'b0, 8'h00, 2'd0, 8'hA5, 1'b0);
    chk({tag, "_settle_gap"}, 64'(last_rise - ptr_stop_rsp >= 100), 64'd1);
    for (int i = 0; i < 6; i++)
      xcmd({tag, "_byte"}, 1'b0, r[47-8*i -: 8], 2'd2, 8'h00, 1'(i == 5));
    xcmd({tag, "_stop"}, 1'b0, 8'h00, 2'd3, 8'h00, 1'b0);
    tick();
    e = exp_q.pop_front();
    chk({tag, "_decode"}, 64'(obs()), 64'(e));
  endtask

  initial begin
    int p1, p2, t0;
    model_clear();
    repeat (3) tick();
    chk("rst_outs", 64'(obs()), 64'd0);
    chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    reset = 1'b0;

    do_init1();
    do_init2();
    do_ptr();
    p1 = ptr_rise;
    do_read("r1", R1);
`ifdef WII_CAL_EN
    chk("cal_skip_lx", 64'(l_stick_x), 64'd0);
    chk("cal_skip_conn", 64'(connected), 64'd0);
`else
    chk("r1_abxy", 64'(abxy_btns), 64'h8);
    chk("r1_dpad", 64'(udlr_dpad), 64'h0);
    chk("r1_lx", 64'(l_stick_x), 64'h20);
    chk("r1_ly", 64'(l_stick_y), 64'h20);
    chk("r1_ry", 64'(r_stick_y), 64'h10);
    chk("r1_conn", 64'(connected), 64'd1);
`endif

    do_ptr();
    p2 = ptr_rise;
    chk("poll_period", 64'(p2 - p1), 64'd1000);
    do_read("r2", R2);
`ifdef WII_CAL_EN
    chk("cal_lx", 64'(l_stick_x), 64'h2C);
`endif

    repeat (20) tick();
    rsp_valid = 1'b1; rsp_nack = 1'b1;
    tick();
    rsp_valid = 1'b0; rsp_nack = 1'b0;
    repeat (2) tick();
    chk("stray_rsp", 64'(obs()), 64'(m_cur));
    chk("stray_cmd", 64'(cmd_valid), 64'd0);

    xcmd("ptr_nack", 1'b1, 8'h00, 2'd0, 8'hA4, 1'b0);
    chk("poll_period2", 64'(last_rise - p2), 64'd1000);
    model_clear();
    chk("nack_clear", 64'(obs()), 64'd0);
    xcmd("err_stop", 1'b0, 8'h00, 2'd3, 8'h00, 1'b0);
    t0 = last_rsp;
    xcmd("retry_i1_start", 1'b0, 8'h00, 2'd0, 8'hA4, 1'b0);
    chk("backoff_gap", 64'(last_rise - t0 >= 500 && last_rise - t0 < 520), 64'd1);
    xcmd("retry_i1_f0",   1'b0, 8'h00, 2'd1, 8'hF0, 1'b0);
    xcmd("retry_i1_55",   1'b0, 8'h00, 2'd1, 8'h55, 1'b0);
    xcmd("retry_i1_stop", 1'b0, 8'h00, 2'd3, 8'h00, 1'b0);
    xcmd("i2n_start",     1'b0, 8'h00, 2'd0, 8'hA4, 1'b0);
    xcmd("i2n_fb_nack",   1'b1, 8'h00, 2'd1, 8'hFB, 1'b0);
    model_clear();
    chk("i2_nack_outs", 64'(obs()), 64'd0);
    xcmd("i2n_err_stop",  1'b0, 8'h00, 2'd3, 8'h00, 1'b0);
    t0 = last_rsp;
    do_init1();
    chk("backoff_gap2", 64'(last_rise - t0 >= 500), 64'd1);
    do_init2();
    do_ptr();
    do_read("r3", R3);

    do_ptr();
    xcmd("mr_start", 1'b0, 8'h00, 2'd0, 8'hA5, 1'b0);
    xcmd("mr_byte0", 1'b0, 8'h5A, 2'd2, 8'h00, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    model_clear();
    chk("mid_rst_outs", 64'(obs()), 64'd0);
    chk("mid_rst_cmd_valid", 64'(cmd_valid), 64'd0);
    repeat (2) tick();
    reset = 1'b0;
    xcmd("post_rst_i1_start", 1'b0, 8'h00, 2'd0, 8'hA4, 1'b0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
